// File: rtl/wr_control_deskew_if.sv
// ---------------------------------------------------------------------------
// wr_control_deskew_if
//
// Bundles the start/busy/done handshake and the per-lane write bus of the
// result write-back sequencer.
//
// Signals:
//   start      controller -> sequencer  request a write burst
//   base_addr  controller -> sequencer  first row address for every lane
//   num_rows   controller -> sequencer  rows written per lane
//   busy       sequencer -> controller  burst in progress
//   done       sequencer -> controller  one-cycle completion pulse
//   wr_en      sequencer -> memory      per-lane write enable (bit i = column i)
//   wr_addr    sequencer -> memory      packed lane addresses, lane i at
//                                       [i*addr_width +: addr_width]
//
// Modports:
//   master  the controller / memory side that drives start and observes writes
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface wr_control_deskew_if #(
  parameter int width_height = 4,
  parameter int addr_width   = 8
);

  logic                               start;
  logic [addr_width-1:0]              base_addr;
  logic [addr_width-1:0]              num_rows;
  logic                               busy;
  logic                               done;
  logic [width_height-1:0]            wr_en;
  logic [width_height*addr_width-1:0] wr_addr;

  modport master (
    output start, base_addr, num_rows,
    input  busy, done, wr_en, wr_addr
  );

  modport slave (
    input  start, base_addr, num_rows,
    output busy, done, wr_en, wr_addr
  );

endinterface

// File: rtl/wr_control_deskew.sv
// ---------------------------------------------------------------------------
// wr_control_deskew
//
// Result write-back sequencer sitting downstream of the systolic array.
// Array output columns emerge skewed by one cycle per column, so this block
// produces matching staggered per-lane write enables and addresses; every
// column then lands row-aligned in the output memory.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    wr_control_deskew_if.slave
//            start/base_addr/num_rows in, busy/done/wr_en/wr_addr out
//
// Parameters:
//   width_height  number of array columns (= write lanes)
//   addr_width    per-lane address width
//   latency       cycles from accepted start to the first lane-0 result
// ---------------------------------------------------------------------------
module wr_control_deskew #(
  parameter int width_height = 4,
  parameter int addr_width   = 8,
  parameter int latency      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  wr_control_deskew_if.slave    bus
);

  // Master counter must reach num_rows + width_height - 2 without overflow,
  // even for the largest num_rows.
  localparam int cnt_width = addr_width + $clog2(width_height) + 1;
  localparam int lat_width = (latency > 1) ? $clog2(latency) : 1;
  localparam int lat_last  = (latency > 0) ? latency - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM,
    DONE
  } state_t;

  state_t                             state;
  logic [cnt_width-1:0]               cnt;
  logic [lat_width-1:0]               wait_cnt;
  logic [addr_width-1:0]              base_q;
  logic [addr_width-1:0]              rows_q;

  logic [cnt_width-1:0]               last_cnt;
  logic [cnt_width-1:0]               lane_off;
  logic [width_height-1:0]            lane_en;
  logic [width_height*addr_width-1:0] lane_addr;

  // Final value of the master counter: the last lane finishes its last row
  // width_height-1 counts after lane 0 does. Only used when rows_q > 0.
  assign last_cnt = cnt_width'(rows_q) + cnt_width'(width_height) - cnt_width'(2);

  // Lane i is delayed by i counts. It writes while its own row offset
  // (cnt - i) lies in [0, rows_q); the address wraps modulo 2^addr_width.
  always_comb begin
    lane_en   = '0;
    lane_addr = '0;
    lane_off  = '0;
    for (int i = 0; i < width_height; i++) begin
      lane_off = cnt - cnt_width'(i);
      if ((cnt >= cnt_width'(i)) && (lane_off < cnt_width'(rows_q))) begin
        lane_en[i] = 1'b1;
        lane_addr[i*addr_width +: addr_width] = base_q + lane_off[addr_width-1:0];
      end
    end
  end

  // Sequencer FSM. Outputs are registered: the enables computed from cnt in
  // STREAM become visible one cycle later, so the DONE state cycle still
  // shows the final write and done itself appears in the cycle after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wait_cnt    <= '0;
      base_q      <= '0;
      rows_q      <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wr_en   <= '0;
      bus.wr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            base_q   <= bus.base_addr;
            rows_q   <= bus.num_rows;
            bus.busy <= 1'b1;
            cnt      <= '0;
            wait_cnt <= '0;
            if (bus.num_rows == '0) begin
              state <= DONE;
            end else if (latency == 0) begin
              state <= STREAM;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (wait_cnt == lat_width'(lat_last)) begin
            wait_cnt <= '0;
            state    <= STREAM;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        STREAM: begin
          bus.wr_en   <= lane_en;
          bus.wr_addr <= lane_addr;
          if (cnt == last_cnt) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          bus.wr_en   <= '0;
          bus.wr_addr <= '0;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          cnt         <= '0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wr_control_deskew.sv
// ---------------------------------------------------------------------------
// tb_wr_control_deskew
//
// Drives two sequencers (latency 2 and latency 0) from one shared stimulus
// stream. A reference model works purely from the timing rules: when a start
// is accepted at edge T it lists every write cycle, lane row and address,
// the done cycle and the busy window, and queues them. A monitor on the
// falling edge pops the queue and compares whenever a write or done is due.
// ---------------------------------------------------------------------------
module tb_wr_control_deskew;

  localparam int W    = 4;
  localparam int AW   = 8;
  localparam int NDUT = 2;

  typedef struct {
    int              cyc;
    logic [W-1:0]    en;
    logic [W*AW-1:0] addr;
    logic            done;
  } rec_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   num_rows;

  logic [W-1:0]    en_s   [NDUT];
  logic [W*AW-1:0] addr_s [NDUT];
  logic            busy_s [NDUT];
  logic            done_s [NDUT];

  rec_t exp_q [NDUT][$];
  int   busy_from [NDUT];
  int   busy_to   [NDUT];
  int   free_edge [NDUT];
  int   lat_of    [NDUT];

  int cyc;
  int checks;
  int errors;

  wr_control_deskew_if #(.width_height(W), .addr_width(AW)) bus0 ();
  wr_control_deskew_if #(.width_height(W), .addr_width(AW)) bus1 ();

  wr_control_deskew #(.width_height(W), .addr_width(AW), .latency(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  wr_control_deskew #(.width_height(W), .addr_width(AW), .latency(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus0.start     = start;
  assign bus0.base_addr = base_addr;
  assign bus0.num_rows  = num_rows;
  assign bus1.start     = start;
  assign bus1.base_addr = base_addr;
  assign bus1.num_rows  = num_rows;

  assign en_s[0]   = bus0.wr_en;
  assign addr_s[0] = bus0.wr_addr;
  assign busy_s[0] = bus0.busy;
  assign done_s[0] = bus0.done;
  assign en_s[1]   = bus1.wr_en;
  assign addr_s[1] = bus1.wr_addr;
  assign busy_s[1] = bus1.busy;
  assign done_s[1] = bus1.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of a burst accepted at edge t: lane i writes row k in
  // cycle t+1+lat+i+k for k in [0, rows); done follows the last lane's last
  // row; busy covers t up to the cycle before done.
  function automatic void push_burst(int d, int t, int lat, logic [AW-1:0] base, int rows);
    rec_t          r;
    int            first;
    int            done_cyc;
    int            k;
    logic [AW-1:0] a;
    if (rows == 0) begin
      done_cyc = t + 1;
    end else begin
      first    = t + 1 + lat;
      done_cyc = t + lat + W + rows;
      for (int c = first; c < done_cyc; c++) begin
        r.cyc  = c;
        r.en   = '0;
        r.addr = '0;
        r.done = 1'b0;
        for (int i = 0; i < W; i++) begin
          k = c - first - i;
          if (k >= 0 && k < rows) begin
            a = base + AW'(k);
            r.en[i] = 1'b1;
            r.addr[i*AW +: AW] = a;
          end
        end
        exp_q[d].push_back(r);
      end
    end
    r.cyc  = done_cyc;
    r.en   = '0;
    r.addr = '0;
    r.done = 1'b1;
    exp_q[d].push_back(r);
    busy_from[d] = t;
    busy_to[d]   = done_cyc - 1;
    free_edge[d] = done_cyc + 1;
  endfunction

  // Acceptance model: a sequencer takes start at any edge from its free edge
  // onward, provided reset is released.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      for (int d = 0; d < NDUT; d++) begin
        if (start && cyc >= free_edge[d]) begin
          push_burst(d, cyc, lat_of[d], base_addr, int'(num_rows));
        end
      end
    end
  end

  // Compares one sequencer's outputs against the model for the current cycle.
  task automatic check_output(int d);
    rec_t r;
    logic exp_busy;
    exp_busy = (cyc >= busy_from[d]) && (cyc <= busy_to[d]);
    checks++;
    if (busy_s[d] !== exp_busy) begin
      errors++;
      $display("[TB] FAIL busy dut%0d cycle %0d: got %b expected %b", d, cyc, busy_s[d], exp_busy);
    end
    while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
      r = exp_q[d].pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missed_event dut%0d cycle %0d: expected en %b done %b, never compared", d, r.cyc, r.en, r.done);
    end
    if (exp_q[d].size() > 0 && exp_q[d][0].cyc == cyc) begin
      r = exp_q[d].pop_front();
      checks++;
      if (en_s[d] !== r.en || addr_s[d] !== r.addr || done_s[d] !== r.done) begin
        errors++;
        $display("[TB] FAIL write dut%0d cycle %0d: got en %b addr %h done %b expected en %b addr %h done %b",
                 d, cyc, en_s[d], addr_s[d], done_s[d], r.en, r.addr, r.done);
      end
    end else begin
      checks++;
      if (en_s[d] !== '0 || addr_s[d] !== '0 || done_s[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL quiet dut%0d cycle %0d: got en %b addr %h done %b expected all zero",
                 d, cyc, en_s[d], addr_s[d], done_s[d]);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      check_output(d);
    end
  end

  // Waits (bounded) until the model says both sequencers are idle at the
  // next edge.
  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((cyc + 1 < free_edge[0] || cyc + 1 < free_edge[1]) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Asserts reset a little after a rising edge and holds it for n cycles.
  task automatic apply_reset(int n);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      exp_q[d].delete();
      busy_to[d]   = cyc - 1;
      free_edge[d] = 0;
    end
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issues one start with the given inputs held for 'hold' cycles, then
  // scrambles base_addr/num_rows so late changes are exercised.
  task automatic apply_stimulus(logic [AW-1:0] base, logic [AW-1:0] rows, int hold);
    wait_idle();
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    num_rows  = rows;
    repeat (hold) @(negedge clk);
    start     = 1'b0;
    base_addr = AW'($urandom);
    num_rows  = AW'($urandom);
  endtask

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    lat_of[0] = 2;
    lat_of[1] = 0;
    for (int d = 0; d < NDUT; d++) begin
      busy_from[d] = 0;
      busy_to[d]   = -1;
      free_edge[d] = 0;
    end

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic burst with a stray start (different base) mid-burst.
    apply_stimulus(8'h10, 8'd3, 1);
    repeat (4) @(negedge clk);
    start     = 1'b1;
    base_addr = 8'h40;
    @(negedge clk);
    start     = 1'b0;

    // Zero rows, then address wrap.
    apply_stimulus(8'h22, 8'd0, 1);
    apply_stimulus(8'hFE, 8'd4, 1);

    // Reset in cycle 5 of a basic burst, then a clean burst.
    apply_stimulus(8'h10, 8'd3, 1);
    repeat (4) @(negedge clk);
    apply_reset(2);
    apply_stimulus(8'h10, 8'd3, 1);

    // Single-row bursts with start held high: back-to-back acceptance.
    apply_stimulus(8'h5A, 8'd1, 14);

    // Largest row count.
    apply_stimulus(8'h80, 8'd255, 1);

    // Randomized traffic, inputs changing every cycle.
    wait_idle();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 2) == 0);
      base_addr = AW'($urandom);
      num_rows  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) begin
        apply_reset(2);
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("[TB] FAIL leftover dut%0d: got %0d pending events expected 0", d, exp_q[d].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_control_deskew.md
Name: wr_control_deskew

Overview:
- Result write-back sequencer, downstream of the systolic array.
- Array output columns emerge skewed by one cycle per column.
- This block generates the matching staggered per-lane write enables and addresses, so each output column lands row-aligned in the output memory array.
- Controlled by a start/busy/done handshake from the top-level controller.

Parameters:
- width_height, 4, number of array columns = write lanes
- addr_width, 8, per-lane address width
- latency, 2, cycles from accepted start to the first lane-0 result (array pipeline fill); 0 allowed

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset; all state and outputs cleared while low
- start  input  1  request to begin a write burst; sampled only in IDLE
- base_addr  input  addr_width  first row address written by every lane; captured at start
- num_rows  input  addr_width  rows per lane; captured at start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last write
- wr_en  output  width_height  per-lane write enable; bit i = column i
- wr_addr  output  width_height*addr_width  packed lane addresses; lane i at bits [i*addr_width +: addr_width]

Behaviour:
- Reset: while reset is low, the block is in IDLE and busy=0, done=0, wr_en=0, wr_addr=0, and all internal counters are 0.
- Cycle convention: cycle n is the interval after rising edge n. All outputs are registered.
- Start acceptance: in IDLE with start=1 at edge T, the block latches base_addr and num_rows (R) and sets busy=1 from cycle T.
- States:
  - IDLE -> WAIT on start with R>0.
  - IDLE -> DONE on start with R=0; no writes occur.
  - WAIT counts latency cycles, then -> STREAM. WAIT is skipped when latency=0.
  - STREAM runs a master counter cnt from 0 to R+width_height-2, then -> DONE.
  - DONE lasts one cycle, then -> IDLE.
- Lane enables: lane i is enabled when cnt>=i and cnt-i<R. Therefore wr_en[i] is high in cycles T+1+latency+i through T+latency+i+R, i.e. exactly R consecutive cycles.
- Lane addresses: an enabled lane i drives base_addr+(cnt-i), computed modulo 2^addr_width so it wraps silently. A disabled lane drives 0.
- Completion: done=1 and busy=0 in cycle T+latency+width_height+R. With R=0, done is in cycle T+1.
- start while busy is ignored. It is neither queued nor does it alter the latched inputs.
- start is re-accepted at the edge following the DONE cycle, i.e. the cycle done is high is not an acceptance edge.
- Changes to base_addr/num_rows after acceptance have no effect on the current burst.
- Reset asserted mid-burst: the burst is aborted immediately and asynchronously, with no done pulse. After reset is released, the block is in IDLE.
- Arithmetic: cnt is addr_width+log2(width_height)+1 bits wide so R=2^addr_width-1 does not overflow.

Test Plan:
- Basic burst: defaults, base_addr=0x10, num_rows=3, start at edge 0.
  - wr_en in cycles 3..8 = 0001, 0011, 0111, 1110, 1100, 1000.
  - Lane 0 addresses 0x10, 0x11, 0x12 in cycles 3..5; lane 3 addresses 0x10, 0x11, 0x12 in cycles 6..8.
  - done in cycle 9; busy high in cycles 0..8.
- Zero rows: num_rows=0 -> wr_en stays 0, done in cycle 1, busy high in cycle 0 only.
- Wrap: base_addr=0xFE, num_rows=4 -> every lane writes 0xFE, 0xFF, 0x00, 0x01 with no error indication.
- Start while busy: pulse start with base_addr=0x40 at cycle 5 of the basic burst -> burst is unchanged; no second burst follows done.
- Reset mid-burst: drop reset in cycle 5 of the basic burst -> wr_en=0 and busy=0 immediately, with no done pulse. A new start after release runs a clean full burst.
- Back-to-back and latency=0:
  - With latency=0, num_rows=1 -> wr_en = 0001, 0010, 0100, 1000 in cycles 1..4, all addresses = base_addr, done in cycle 5.
  - start held high -> the next burst is accepted at edge 6.
